// File: rtl/mdu_ex.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/multu/div/divu
// and raises Busy for the hazard unit while a calculation is in flight.
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    logic        issue_ok;
    logic        is_mult_op;
    logic        op_is_div;
    logic        div_by_zero;
    logic        signed_div;
    logic        quot_neg;
    logic        rem_neg;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign issue_ok   = Start && !Req && (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
    assign is_mult_op = (MDUop == OP_MULT) || (MDUop == OP_MULTU);

    // Arithmetic always works from the operands latched at issue.
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};
    assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});

    // One unsigned divider serves both divides; signed div runs on magnitudes and
    // fixes signs afterwards, which also yields 0x80000000 / -1 = 0x80000000.
    assign op_is_div   = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    assign div_by_zero = (b_reg == 32'd0);
    assign signed_div  = (op_reg == OP_DIV);
    assign dividend    = (signed_div && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
    assign divisor     = div_by_zero ? 32'd1 :
                         ((signed_div && b_reg[31]) ? (32'd0 - b_reg) : b_reg);
    assign quot_mag    = dividend / divisor;
    assign rem_mag     = dividend % divisor;
    assign quot_neg    = signed_div && (a_reg[31] ^ b_reg[31]);
    assign rem_neg     = signed_div && a_reg[31];

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_reg)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem_neg  ? (32'd0 - rem_mag)  : rem_mag;
                res_lo = quot_neg ? (32'd0 - quot_mag) : quot_mag;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (issue_ok) begin
                    state_next = CALC;
                    cnt_next   = is_mult_op ? MULT_LOAD : DIV_LOAD;
                    op_next    = MDUop;
                    a_next     = A;
                    b_next     = B;
                end else if (!Req && MDUop == OP_MTHI) begin
                    hi_next = A;
                end else if (!Req && MDUop == OP_MTLO) begin
                    lo_next = A;
                end
            end
            CALC: begin
                // Req is deliberately ignored here: the instruction has already retired.
                cnt_next = cnt_reg - CNT_LAST;
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    if (!(op_is_div && div_by_zero)) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign Busy = (state_reg == CALC);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    always_comb begin
        MDU_out = 32'd0;
        if (MDUop == OP_MFHI)
            MDU_out = hi_reg;
        else if (MDUop == OP_MFLO)
            MDU_out = lo_reg;
    end

endmodule
